masku_cmp_sequencer: RTL
========================

// Module: masku_cmp_sequencer
// PURPOSE
//  Sequences the mask-unit compress datapath for mask-producing instructions
//  (compares, VMADC/VMSBC). Accepts one instruction, consumes operand beats
//  from the lanes and drives the bit pointer vrf_pnt_o into the compressor.
//  OR-accumulates the compressed bits into a DATAPATH_WIDTH-bit mask word and
//  emits the word for VRF writeback when it is full or when vl is exhausted.
// PARAMETERS
//  NrLanes  4   number of lanes; DATAPATH_WIDTH = NrLanes*ELEN (ELEN from ara_pkg)
//  VlWidth  16  width of the vl counter (must hold MAXVL)
// PORTS
//  clk_i            in   1                 clock
//  rst_i            in   1                 synchronous, active-high reset
//  vinsn_valid_i    in   1                 new mask instruction offered
//  vinsn_ready_o    out  1                 instruction accepted (IDLE only)
//  vinsn_vl_i       in   VlWidth           element count of the instruction
//  vinsn_vsew_i     in   vew_e             source SEW (EW8..EW64)
//  operand_valid_i  in   1                 operand beat (all lanes) available
//  operand_ready_o  out  1                 beat consumed this cycle
//  compressed_i     in   DATAPATH_WIDTH    compressor output for current beat/vrf_pnt_o
//  vrf_pnt_o        out  idx_width(DATAPATH_WIDTH)+1  result bit pointer
//  result_valid_o   out  1                 mask word ready for writeback
//  result_ready_i   in   1                 writeback accepts word
//  result_o         out  DATAPATH_WIDTH    accumulated mask word
//  result_last_o    out  1                 word is the final one of the instruction
//  vinsn_done_o     out  1                 one-cycle pulse: instruction committed
//  busy_o           out  1                 state != IDLE
// BEHAVIOUR
//  - E = DATAPATH_WIDTH >> (3+vsew) elements (= result bits) per beat.
//  - Registers: state, remaining (VlWidth), vrf_pnt, acc, eew (latched vsew).
//  - Reset: state=IDLE, remaining=0, vrf_pnt=0, acc=0; all outputs 0 except
//    vinsn_ready_o=1. Reset in any state drops the in-flight instruction.
//  - IDLE: vinsn_ready_o=1. On valid, latch vl/vsew.
//    - vl=0: go DONE.
//    - Otherwise go ACCUM; vrf_pnt=0, acc=0.
//  - ACCUM: operand_ready_o=1. Handshake = operand_valid_i & operand_ready_o.
//    On each handshake:
//    - acc |= compressed_i; n = min(E, remaining); remaining -= n; vrf_pnt += E.
//    - If remaining hits 0 or vrf_pnt+E == DATAPATH_WIDTH: go FLUSH next cycle.
//  - FLUSH: result_valid_o=1; result_o=acc; result_last_o=(remaining==0);
//    operand_ready_o=0. All three outputs stay stable until result_ready_i.
//    - On accept: acc=0, vrf_pnt=0. If remaining==0 go DONE, else go ACCUM.
//  - DONE: vinsn_done_o=1 for exactly one cycle; next state is IDLE.
//  - vrf_pnt_o = vrf_pnt, combinational from the register; valid while in ACCUM.
//    vrf_pnt_o is 0 in all other states.
//  - Tail bits beyond vl are taken unchanged from compressed_i. The datapath
//    applies the vl/mask enables; the sequencer does not mask.
//  - Latency: instruction accept -> first beat ready 1 cycle. Filling beat ->
//    result_valid_o 1 cycle. Last result accept -> vinsn_done_o 1 cycle.
//  - remaining never underflows: n is clamped. The counters are sized so
//    vrf_pnt never exceeds DATAPATH_WIDTH.
// TESTING (NrLanes=4, DATAPATH_WIDTH=256)
//  1 vl=32,EW8: 1 beat at vrf_pnt 0 -> one result, last=1, done pulse 1 cycle after accept.
//  2 vl=256,EW8: 8 beats, vrf_pnt_o 0,32,..,224 -> single result=OR of compressed_i, last=1.
//  3 vl=70,EW64 (E=4): 18 beats, vrf_pnt_o 0..68 step 4 -> one result, last=1.
//  4 vl=300,EW8: 8 beats -> result last=0; vrf_pnt resets to 0; 2 beats -> result last=1.
//  5 result_ready_i held 0 for 5 cycles in FLUSH -> result_o stable, operand_ready_o=0, no beats consumed.
//  6 vl=0 -> done pulse with no result; rst_i mid-ACCUM -> IDLE next cycle, outputs at reset values.

Source files
------------

// File: rtl/masku_cmp_sequencer.sv
// rtl/masku_cmp_sequencer.sv - mask-unit compress sequencer for mask-producing instructions
module masku_cmp_sequencer #(
   parameter int unsigned NrLanes = 4,
   parameter int unsigned VlWidth = 16,
   localparam int unsigned Elen = 64,
   localparam int unsigned DataWidth = NrLanes * Elen,
   localparam int unsigned PntWidth = $clog2(DataWidth) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 vinsn_valid_i,
   output logic                 vinsn_ready_o,
   input  logic [VlWidth-1:0]   vinsn_vl_i,
   input  logic [1:0]           vinsn_vsew_i,
   input  logic                 operand_valid_i,
   output logic                 operand_ready_o,
   input  logic [DataWidth-1:0] compressed_i,
   output logic [PntWidth-1:0]  vrf_pnt_o,
   output logic                 result_valid_o,
   input  logic                 result_ready_i,
   output logic [DataWidth-1:0] result_o,
   output logic                 result_last_o,
   output logic                 vinsn_done_o,
   output logic                 busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e               state_q;
   logic [VlWidth-1:0]   remaining_q;
   logic [PntWidth-1:0]  vrf_pnt_q;
   logic [DataWidth-1:0] acc_q;
   logic [1:0]           eew_q;

   logic vinsn_ready_q;
   logic operand_ready_q;
   logic result_valid_q;
   logic result_last_q;
   logic done_q;
   logic busy_q;

   logic [PntWidth-1:0] elems;
   logic [VlWidth-1:0]  elems_vl;
   logic [VlWidth-1:0]  n_take;
   logic                vl_exhausted;
   logic                word_full;
   logic                beat_hs;

   // Per-beat element count from the latched SEW, clamped take, and word-fill detection
   always_comb begin
      elems        = PntWidth'(DataWidth >> (32'd3 + 32'(eew_q)));
      elems_vl     = VlWidth'(elems);
      n_take       = (elems_vl < remaining_q) ? elems_vl : remaining_q;
      vl_exhausted = (remaining_q == n_take);
      word_full    = ((vrf_pnt_q + elems) == PntWidth'(DataWidth));
      beat_hs      = operand_valid_i & operand_ready_q;
   end

   // Sequencer FSM: state, counters, accumulator and registered handshake outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         remaining_q     <= '0;
         vrf_pnt_q       <= '0;
         acc_q           <= '0;
         eew_q           <= '0;
         vinsn_ready_q   <= 1'b1;
         operand_ready_q <= 1'b0;
         result_valid_q  <= 1'b0;
         result_last_q   <= 1'b0;
         done_q          <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (vinsn_valid_i) begin
                  eew_q         <= vinsn_vsew_i;
                  remaining_q   <= vinsn_vl_i;
                  vrf_pnt_q     <= '0;
                  acc_q         <= '0;
                  vinsn_ready_q <= 1'b0;
                  busy_q        <= 1'b1;
                  if (vinsn_vl_i == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q         <= ACCUM;
                     operand_ready_q <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (beat_hs) begin
                  acc_q       <= acc_q | compressed_i;
                  remaining_q <= remaining_q - n_take;
                  vrf_pnt_q   <= vrf_pnt_q + elems;
                  if (vl_exhausted || word_full) begin
                     state_q         <= FLUSH;
                     operand_ready_q <= 1'b0;
                     result_valid_q  <= 1'b1;
                     result_last_q   <= vl_exhausted;
                  end
               end
            end
            FLUSH: begin
               if (result_ready_i) begin
                  acc_q          <= '0;
                  vrf_pnt_q      <= '0;
                  result_valid_q <= 1'b0;
                  result_last_q  <= 1'b0;
                  if (remaining_q == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q         <= ACCUM;
                     operand_ready_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q       <= IDLE;
               done_q        <= 1'b0;
               busy_q        <= 1'b0;
               vinsn_ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign vinsn_ready_o   = vinsn_ready_q;
   assign operand_ready_o = operand_ready_q;
   assign result_valid_o  = result_valid_q;
   assign result_last_o   = result_last_q;
   assign result_o        = acc_q;
   assign vinsn_done_o    = done_q;
   assign busy_o          = busy_q;
   assign vrf_pnt_o       = (state_q == ACCUM) ? vrf_pnt_q : '0;

endmodule
